// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock controller.
package chess_clock_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned DIGIT_CNT = 8;

  localparam int unsigned DIG_P1_MT = 0;
  localparam int unsigned DIG_P1_MU = 1;
  localparam int unsigned DIG_P1_ST = 2;
  localparam int unsigned DIG_P1_SU = 3;
  localparam int unsigned DIG_P2_MT = 4;
  localparam int unsigned DIG_P2_MU = 5;
  localparam int unsigned DIG_P2_ST = 6;
  localparam int unsigned DIG_P2_SU = 7;

  localparam logic [DIGIT_CNT-1:0] BLANK_P1 = 8'h0F;
  localparam logic [DIGIT_CNT-1:0] BLANK_P2 = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN1  = 3'd1,
    ST_RUN2  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // One BCD digit down-step, wrapping 0 to the given top value.
  function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t top);
    return (d == '0) ? top : bcd_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/chess_clock_ctrl_bcd_mmss_down.sv
// mm:ss BCD down-counter for one player; saturates at 00:00.
module bcd_mmss_down
  import chess_clock_pkg::*;
#(
  parameter int unsigned START_MIN = 5,
  parameter int unsigned START_SEC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic load,
  input  logic dec,
  output bcd_t m_tens,
  output bcd_t m_units,
  output bcd_t s_tens,
  output bcd_t s_units,
  output logic zero,
  output logic last_sec
);

  localparam bcd_t R_MT = bcd_t'(START_MIN / 10);
  localparam bcd_t R_MU = bcd_t'(START_MIN % 10);
  localparam bcd_t R_ST = bcd_t'(START_SEC / 10);
  localparam bcd_t R_SU = bcd_t'(START_SEC % 10);

  bcd_t mt_q, mu_q, st_q, su_q;
  bcd_t mt_d, mu_d, st_d, su_d;

  assign zero     = (mt_q == '0) && (mu_q == '0) && (st_q == '0) && (su_q == '0);
  assign last_sec = (mt_q == '0) && (mu_q == '0) && (st_q == '0) && (su_q == 4'd1);

  // Reload or borrow-chained decrement of the four digits.
  always_comb begin
    mt_d = mt_q;
    mu_d = mu_q;
    st_d = st_q;
    su_d = su_q;
    if (ce) begin
      if (load) begin
        mt_d = R_MT;
        mu_d = R_MU;
        st_d = R_ST;
        su_d = R_SU;
      end else if (dec && !zero) begin
        su_d = bcd_dec(su_q, 4'd9);
        if (su_q == '0) begin
          st_d = bcd_dec(st_q, 4'd5);
          if (st_q == '0) begin
            mu_d = bcd_dec(mu_q, 4'd9);
            if (mu_q == '0) begin
              mt_d = bcd_dec(mt_q, 4'd9);
            end
          end
        end
      end
    end
  end

  // Digit registers, reset to the reload time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mt_q <= R_MT;
      mu_q <= R_MU;
      st_q <= R_ST;
      su_q <= R_SU;
    end else begin
      mt_q <= mt_d;
      mu_q <= mu_d;
      st_q <= st_d;
      su_q <= su_d;
    end
  end

  assign m_tens  = mt_q;
  assign m_units = mu_q;
  assign s_tens  = st_q;
  assign s_units = su_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock: game FSM, blink control and per-player counters.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int unsigned START_MIN = 5,
  parameter int unsigned START_SEC = 0
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic                         CE,
  input  logic                         TICK,
  input  logic                         btn_p1,
  input  logic                         btn_p2,
  input  logic                         btn_pause,
  input  logic                         btn_rst,
  output logic [DIGIT_CNT*DIGIT_W-1:0] digits,
  output logic [DIGIT_CNT-1:0]         blank,
  output logic [2:0]                   state,
  output logic                         timeout_p1,
  output logic                         timeout_p2
);

  state_e state_q, state_d;
  state_e saved_q, saved_d;
  logic   to1_q, to1_d, to2_q, to2_d;
  logic [DIGIT_CNT-1:0] blank_q, blank_d;

  logic load, dec1, dec2;
  logic p1_zero, p1_last, p2_zero, p2_last;
  bcd_t p1_mt, p1_mu, p1_st, p1_su;
  bcd_t p2_mt, p2_mu, p2_st, p2_su;

  bcd_mmss_down #(.START_MIN(START_MIN), .START_SEC(START_SEC)) u_p1 (
    .clk(CLK), .rst(CLR), .ce(CE), .load(load), .dec(dec1),
    .m_tens(p1_mt), .m_units(p1_mu), .s_tens(p1_st), .s_units(p1_su),
    .zero(p1_zero), .last_sec(p1_last)
  );

  bcd_mmss_down #(.START_MIN(START_MIN), .START_SEC(START_SEC)) u_p2 (
    .clk(CLK), .rst(CLR), .ce(CE), .load(load), .dec(dec2),
    .m_tens(p2_mt), .m_units(p2_mu), .s_tens(p2_st), .s_units(p2_su),
    .zero(p2_zero), .last_sec(p2_last)
  );

  // Next-state: game reset beats timeout beats pause beats player buttons.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    to1_d   = to1_q;
    to2_d   = to2_q;
    blank_d = blank_q;
    load    = 1'b0;
    dec1    = 1'b0;
    dec2    = 1'b0;
    if (CE) begin
      if (btn_rst) begin
        state_d = ST_IDLE;
        saved_d = ST_RUN1;
        to1_d   = 1'b0;
        to2_d   = 1'b0;
        blank_d = '0;
        load    = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (btn_p1 && !btn_p2)      state_d = ST_RUN2;
            else if (btn_p2 && !btn_p1) state_d = ST_RUN1;
          end
          ST_RUN1: begin
            dec1 = TICK;
            if (p1_zero || (TICK && p1_last)) begin
              state_d = ST_DONE;
              to1_d   = 1'b1;
            end else if (btn_pause) begin
              state_d = ST_PAUSE;
              saved_d = ST_RUN1;
            end else if (btn_p1) begin
              state_d = ST_RUN2;
            end
          end
          ST_RUN2: begin
            dec2 = TICK;
            if (p2_zero || (TICK && p2_last)) begin
              state_d = ST_DONE;
              to2_d   = 1'b1;
            end else if (btn_pause) begin
              state_d = ST_PAUSE;
              saved_d = ST_RUN2;
            end else if (btn_p2) begin
              state_d = ST_RUN1;
            end
          end
          ST_PAUSE: begin
            if (btn_pause) begin
              state_d = saved_q;
              blank_d = '0;
            end else if (TICK) begin
              blank_d = blank_q ^ ((saved_q == ST_RUN1) ? BLANK_P1 : BLANK_P2);
            end
          end
          ST_DONE: begin
            if (TICK) blank_d = blank_q ^ (to1_q ? BLANK_P1 : BLANK_P2);
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Control registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      saved_q <= ST_RUN1;
      to1_q   <= 1'b0;
      to2_q   <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      to1_q   <= to1_d;
      to2_q   <= to2_d;
      blank_q <= blank_d;
    end
  end

  // Pack registered counter digits into the display bus.
  always_comb begin
    digits = '0;
    digits[DIG_P1_MT*DIGIT_W +: DIGIT_W] = p1_mt;
    digits[DIG_P1_MU*DIGIT_W +: DIGIT_W] = p1_mu;
    digits[DIG_P1_ST*DIGIT_W +: DIGIT_W] = p1_st;
    digits[DIG_P1_SU*DIGIT_W +: DIGIT_W] = p1_su;
    digits[DIG_P2_MT*DIGIT_W +: DIGIT_W] = p2_mt;
    digits[DIG_P2_MU*DIGIT_W +: DIGIT_W] = p2_mu;
    digits[DIG_P2_ST*DIGIT_W +: DIGIT_W] = p2_st;
    digits[DIG_P2_SU*DIGIT_W +: DIGIT_W] = p2_su;
  end

  assign blank      = blank_q;
  assign state      = state_q;
  assign timeout_p1 = to1_q;
  assign timeout_p2 = to2_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Randomised bench for chess_clock_ctrl against a seconds-based game model.
module tb_chess_clock_ctrl;
  import chess_clock_pkg::*;

  localparam int unsigned SM = 1;
  localparam int unsigned SS = 2;
  localparam int START_T = SM * 60 + SS;

  logic CLK = 1'b0;
  logic CLR, CE, TICK, btn_p1, btn_p2, btn_pause, btn_rst;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [2:0]  state;
  logic        timeout_p1, timeout_p2;

  chess_clock_ctrl #(.START_MIN(SM), .START_SEC(SS)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .TICK(TICK),
    .btn_p1(btn_p1), .btn_p2(btn_p2), .btn_pause(btn_pause), .btn_rst(btn_rst),
    .digits(digits), .blank(blank), .state(state),
    .timeout_p1(timeout_p1), .timeout_p2(timeout_p2)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 running, 2 paused, 3 done; who = active/paused/timed-out player.
  int m_phase, m_who, m_t1, m_t2;
  bit m_to1, m_to2, m_blink;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mmss(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(s % 10), 4'(s / 10), 4'(m % 10), 4'(m / 10)};
  endfunction

  function automatic logic [2:0] exp_state();
    case (m_phase)
      0:       return ST_IDLE;
      1:       return (m_who == 1) ? ST_RUN1 : ST_RUN2;
      2:       return ST_PAUSE;
      default: return ST_DONE;
    endcase
  endfunction

  function automatic logic [7:0] exp_blank();
    if ((m_phase == 2 || m_phase == 3) && m_blink) return (m_who == 1) ? 8'h0F : 8'hF0;
    return 8'h00;
  endfunction

  task automatic check_all();
    check_eq("state",  state,      exp_state());
    check_eq("digits", digits,     {mmss(m_t2), mmss(m_t1)});
    check_eq("blank",  blank,      exp_blank());
    check_eq("to_p1",  timeout_p1, m_to1);
    check_eq("to_p2",  timeout_p2, m_to2);
  endtask

  task automatic model_reset();
    m_phase = 0; m_who = 1; m_t1 = START_T; m_t2 = START_T;
    m_to1 = 0; m_to2 = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit ce, tick, p1, p2, pz, rs);
    int t;
    if (!ce) return;
    if (rs) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        if (p1 && !p2)      begin m_phase = 1; m_who = 2; end
        else if (p2 && !p1) begin m_phase = 1; m_who = 1; end
      end
      1: begin
        if (tick) begin
          t = (m_who == 1) ? m_t1 : m_t2;
          if (t > 0) t--;
          if (m_who == 1) m_t1 = t; else m_t2 = t;
          if (t == 0) begin
            if (m_who == 1) m_to1 = 1; else m_to2 = 1;
            m_phase = 3;
            m_blink = 0;
            return;
          end
        end
        if (pz) begin
          m_phase = 2;
          m_blink = 0;
        end else if (m_who == 1 && p1) m_who = 2;
        else if (m_who == 2 && p2) m_who = 1;
      end
      2: begin
        if (pz) begin m_phase = 1; m_blink = 0; end
        else if (tick) m_blink = ~m_blink;
      end
      default: if (tick) m_blink = ~m_blink;
    endcase
  endtask

  // Called at a falling edge: drive, advance the model, check after the next rising edge.
  task automatic cycle(input bit ce, tick, p1, p2, pz, rs);
    CE = ce; TICK = tick; btn_p1 = p1; btn_p2 = p2; btn_pause = pz; btn_rst = rs;
    model_step(ce, tick, p1, p2, pz, rs);
    @(negedge CLK);
    check_all();
  endtask

  task automatic async_clear();
    CLR = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b0; TICK = 1'b0;
    btn_p1 = 1'b0; btn_p2 = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0;
    model_reset();
    @(negedge CLK);
    check_all();
    CLR = 1'b0;

    cycle(1, 0, 1, 1, 0, 0);                  // both players in IDLE: stay
    cycle(1, 1, 0, 0, 0, 0);                  // TICK ignored in IDLE
    cycle(1, 0, 0, 1, 0, 0);                  // -> RUN1
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);                  // P1 01:00
    cycle(1, 1, 0, 0, 0, 0);                  // P1 00:59
    check_eq("p1_0059", digits[15:0], 16'h9500);
    cycle(1, 1, 1, 0, 0, 0);                  // tick + switch
    check_eq("switch_run2", state, 32'(ST_RUN2));
    cycle(1, 0, 0, 0, 1, 0);                  // pause
    cycle(1, 1, 0, 0, 0, 0);
    check_eq("blink_on", blank[7:4], 4'hF);
    cycle(1, 1, 0, 0, 0, 0);
    check_eq("blink_off", blank[7:4], 4'h0);
    cycle(1, 0, 1, 1, 0, 0);                  // players ignored while paused
    cycle(1, 0, 0, 0, 1, 0);                  // resume RUN2
    repeat (6) cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    repeat (START_T) cycle(1, 1, 0, 0, 0, 0); // P2 runs out
    check_eq("p2_timeout", timeout_p2, 1'b1);
    repeat (4) cycle(1, 1, 1, 1, 1, 0);       // frozen in DONE, blinking
    cycle(1, 0, 0, 0, 0, 1);                  // game reset
    cycle(1, 0, 1, 0, 0, 0);                  // -> RUN2
    repeat (5) cycle(1, 1, 0, 0, 0, 0);
    async_clear();
    cycle(1, 0, 0, 1, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) async_clear();
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 4,  $urandom_range(0, 999) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
